// File: rtl/store_narrow_serializer.sv
// store_narrow_serializer
//
// Takes a 64-bit store operand and an access size (byte/half/word/double).
// It drops the bits above the access width and writes the remaining bytes to
// a byte-wide memory port, one byte per accepted cycle, least significant
// byte first.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_addr            byte address of the least significant byte
//   req_data            store operand (only the low 8*N bits are used)
//   req_size            00=byte, 01=half, 10=word, 11=double
//   mem_we              byte write strobe
//   mem_addr/mem_wdata  address and data of the current byte (0 when idle)
//   mem_ack             memory accepted the current byte
//   busy                a request is in progress
//   done                one-cycle pulse on completion
//   err                 one-cycle pulse when a misaligned request is rejected
//
// All outputs are flops, so there is no combinational path from req_* or
// mem_ack to any output.

module store_narrow_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Index of the last byte for an access size (N-1).
  function automatic logic [2:0] last_idx(input logic [1:0] size);
    case (size)
      2'b00:   last_idx = 3'd0;
      2'b01:   last_idx = 3'd1;
      2'b10:   last_idx = 3'd3;
      default: last_idx = 3'd7;
    endcase
  endfunction

  // Address is misaligned when addr mod N != 0.
  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo[1:0];
      default: misaligned = |addr_lo;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [1:0]  size_q, size_d;

  logic        req_ready_q, req_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          size_d  = req_size;
          idx_d   = 3'd0;
          state_d = misaligned(req_addr[2:0], req_size) ? ERR : SEND;
        end
      end
      SEND: begin
        // A cycle without ack is a stall: idx and therefore the outputs hold.
        if (mem_ack) begin
          if (idx_q == last_idx(size_q)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;  // DONE and ERR last exactly one cycle
    endcase

    // Outputs are computed from the next state and registered.
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
    mem_we_d    = (state_d == SEND);
    mem_addr_d  = 64'd0;
    mem_wdata_d = 8'd0;
    if (state_d == SEND) begin
      mem_addr_d  = addr_d + {61'd0, idx_d};
      mem_wdata_d = data_d[{idx_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      req_ready_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      req_ready_q <= req_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Latched request fields carry no control meaning outside SEND.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    size_q <= size_d;
  end

  assign req_ready = req_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_narrow_serializer.sv
module tb_store_narrow_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];

  store_narrow_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Issue a request now (block must be idle); returns in cycle 1 after acceptance.
  task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    chk("ready_before_accept", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Monitor: pops on every acknowledged byte write and checks stall stability.
  logic        stall_seen = 1'b0;
  logic [63:0] stall_addr;
  logic [7:0]  stall_data;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (stall_seen) begin
        checks++;
        if (mem_addr !== stall_addr || mem_wdata !== stall_data) begin
          errors++;
          $display("FAIL stall_hold: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   mem_addr, mem_wdata, stall_addr, stall_data);
        end
      end
      if (mem_ack === 1'b1) begin
        stall_seen = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                   mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          if (mem_addr !== w.addr || mem_wdata !== w.data) begin
            errors++;
            $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                     mem_addr, mem_wdata, w.addr, w.data);
          end
        end
      end else begin
        stall_seen = 1'b1;
        stall_addr = mem_addr;
        stall_data = mem_wdata;
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 64'd0;
    req_data  = 64'd0;
    req_size  = 2'b00;
    mem_ack   = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_mem_we",    {63'd0, mem_we},    64'd0);
    chk("rst_mem_addr",  mem_addr,           64'd0);
    chk("rst_mem_wdata", {56'd0, mem_wdata}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_done",      {63'd0, done},      64'd0);
    chk("rst_err",       {63'd0, err},       64'd0);

    // Double store: 8 consecutive writes, done in cycle 9.
    push(64'h100, 8'h11); push(64'h101, 8'h22); push(64'h102, 8'h33); push(64'h103, 8'h44);
    push(64'h104, 8'h55); push(64'h105, 8'h66); push(64'h106, 8'h77); push(64'h107, 8'h88);
    issue(64'h100, 64'h8877665544332211, 2'b11);
    chk("dbl_busy_c1", {63'd0, busy}, 64'd1);
    chk("dbl_ready_c1", {63'd0, req_ready}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("dbl_done_low", {63'd0, done}, 64'd0);
      tick();
    end
    chk("dbl_done_c9", {63'd0, done}, 64'd1);
    chk("dbl_we_c9", {63'd0, mem_we}, 64'd0);
    tick();
    chk("dbl_ready_c10", {63'd0, req_ready}, 64'd1);
    chk("dbl_done_c10", {63'd0, done}, 64'd0);

    // Byte truncation: one write only.
    push(64'h203, 8'hAB);
    issue(64'h203, 64'hFFFFFFFFFFFFFFAB, 2'b00);
    tick();
    chk("byte_done_c2", {63'd0, done}, 64'd1);
    tick();
    chk("byte_ready_c3", {63'd0, req_ready}, 64'd1);
    tick();

    // Word with ack low on 2nd and 3rd SEND cycles; done in cycle 7.
    push(64'h40, 8'hEF); push(64'h41, 8'hBE); push(64'h42, 8'hAD); push(64'h43, 8'hDE);
    issue(64'h40, 64'h00000000DEADBEEF, 2'b10);
    tick(); mem_ack = 1'b0;                       // cycle 2
    chk("word_addr_c2", mem_addr, 64'h41);
    tick();                                       // cycle 3
    chk("word_data_c3", {56'd0, mem_wdata}, 64'hBE);
    tick(); mem_ack = 1'b1;                       // cycle 4
    tick();                                       // cycle 5
    tick();                                       // cycle 6
    chk("word_done_c6", {63'd0, done}, 64'd0);
    tick();                                       // cycle 7
    chk("word_done_c7", {63'd0, done}, 64'd1);
    tick();

    // Misaligned half: err in cycle 1, ready in cycle 2, no writes.
    issue(64'h101, 64'h1234, 2'b01);
    chk("mis_err_c1", {63'd0, err}, 64'd1);
    chk("mis_we_c1", {63'd0, mem_we}, 64'd0);
    chk("mis_busy_c1", {63'd0, busy}, 64'd1);
    tick();
    chk("mis_ready_c2", {63'd0, req_ready}, 64'd1);
    chk("mis_err_c2", {63'd0, err}, 64'd0);
    tick();

    // Reset during 3rd SEND cycle of a double store at 0.
    push(64'h0, 8'h01); push(64'h1, 8'h02); push(64'h2, 8'h03);
    issue(64'h0, 64'h0807060504030201, 2'b11);
    tick();
    tick();                                       // cycle 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmb_we", {63'd0, mem_we}, 64'd0);
    chk("rmb_ready", {63'd0, req_ready}, 64'd1);
    chk("rmb_done", {63'd0, done}, 64'd0);
    tick();
    chk("rmb_done_after", {63'd0, done}, 64'd0);
    push(64'h55, 8'h77);
    issue(64'h55, 64'h0000000000000077, 2'b00);
    tick();
    chk("rmb_byte_done", {63'd0, done}, 64'd1);
    tick();

    // Input change after acceptance: only the latched half is written.
    push(64'h10, 8'hFE); push(64'h11, 8'hCA);
    issue(64'h10, 64'h000000000000CAFE, 2'b01);
    req_data = 64'h1122334455667788;
    req_size = 2'b11;
    req_addr = 64'h18;
    tick();
    tick();
    chk("chg_done_c3", {63'd0, done}, 64'd1);
    tick();
    chk("chg_ready_c4", {63'd0, req_ready}, 64'd1);
    tick();
    tick();

    chk("queue_empty", {32'd0, exp_q.size()}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
